ft601_fifo_responder: RTL and testbench
=======================================

# ft601_fifo_responder

Synthesizable device-side model of the FT601 245-synchronous FIFO interface. It is the opposite end of the FPGA's FT601 master: it drives RXF_N/TXE_N, supplies read data on the shared bus, and accepts FPGA writes. It is used as the loopback/stimulus peer in the SERV SoC simulation bench and in an on-FPGA loopback build. Stream ports carry words into the device's RX FIFO (toward the FPGA) and out of its TX FIFO (from the FPGA).

## Interface
- `DepthLog2`, default 4: log2 of the depth of each FIFO (RX and TX each hold 2^DepthLog2 words).
- `clk_i`  in  1  FT601 FIFO clock; all logic is on this one clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `h2f_data_i`  in  32  word to queue for FPGA reads.
- `h2f_be_i`  in  4  byte enables for that word.
- `h2f_valid_i`  in  1  ingress valid.
- `h2f_ready_o`  out  1  ingress ready; high when RX FIFO is not full.
- `f2h_data_o`  out  32  word written by the FPGA.
- `f2h_be_o`  out  4  byte enables of that word.
- `f2h_valid_o`  out  1  egress valid; high when TX FIFO is not empty.
- `f2h_ready_i`  in  1  egress ready.
- `fifo_data_i`  in  32  bus value driven by the FPGA.
- `fifo_data_o`  out  32  bus value driven by the device.
- `fifo_data_oe_o`  out  1  device drive enable, shared by data and BE.
- `fifo_be_i`  in  4  FPGA byte enables.
- `fifo_be_o`  out  4  device byte enables.
- `rxf_n_o`  out  1  low = read data available.
- `txe_n_o`  out  1  low = write space available.
- `rd_n_i`, `wr_n_i`, `oe_n_i`  in  1 each  FPGA strobes, active low.
- `underrun_cnt_o`  out  8  saturating count of illegal reads.
- `overrun_cnt_o`  out  8  saturating count of illegal writes.
- `contention_o`  out  1  sticky bus-contention flag.

## Operation
- The RX FIFO is filled from `h2f_*` and drained by FPGA reads. The TX FIFO is filled by FPGA writes and drained to `f2h_*`.
- Both FIFOs are show-ahead: the head entry is presented combinationally from storage.
- Stream handshakes: a push occurs when valid and ready are both high at a rising edge.
  - Ready and valid are derived only from the registered occupancy.
  - A full FIFO does not accept a push, even if a pop occurs in the same cycle.
- FPGA read: the RX FIFO pops when `rd_n_i`=0, `oe_n_i`=0 and `rxf_n_o`=0 are sampled at an edge.
  - `fifo_data_o`/`fifo_be_o` always show the RX head entry.
  - When the RX FIFO is empty, `fifo_data_o`/`fifo_be_o` show 0.
- An illegal read is `rd_n_i`=0 with `oe_n_i`=0 while `rxf_n_o`=1. It causes no pop and increments `underrun_cnt_o`, saturating at 255.
- FPGA write: the TX FIFO pushes {`fifo_be_i`, `fifo_data_i`} when `wr_n_i`=0, `oe_n_i`=1 and `txe_n_o`=0 are sampled.
- An illegal write is `wr_n_i`=0 while `txe_n_o`=1. It is dropped and increments `overrun_cnt_o`, saturating at 255.
- Bus contention: `wr_n_i`=0 with `oe_n_i`=0 in the same cycle sets `contention_o`.
  - `contention_o` is cleared only by reset.
  - No write is captured in that cycle; a read may still occur.
- Simultaneous push and pop on the same FIFO leaves occupancy unchanged. The occupancy counter is DepthLog2+1 bits wide, and the pointers wrap modulo depth.

## Timing
- Reset values of outputs:
  - `rxf_n_o`=1, `txe_n_o`=1, `fifo_data_oe_o`=0.
  - `h2f_ready_o`=0, `f2h_valid_o`=0.
  - Counters = 0, `contention_o`=0.
  - `fifo_data_o`, `fifo_be_o`, `f2h_data_o`, `f2h_be_o` = 0.
  - Both FIFOs empty.
- After `rst_i` falls, the first rising edge sets `txe_n_o`=0 and `h2f_ready_o`=1.
- `rxf_n_o`, `txe_n_o`, `h2f_ready_o` and `f2h_valid_o` are registered from next-cycle occupancy.
  - A push into an empty RX FIFO at edge N gives `rxf_n_o`=0 in cycle N+1.
  - A pop of the last word at edge N gives `rxf_n_o`=1 in cycle N+1.
- `txe_n_o` rises in the cycle after the write that fills the TX FIFO. A write sampled in that same cycle counts as an overrun.
- `fifo_data_oe_o` is a register of `!oe_n_i`, so the drive enable lags OE_N by one cycle.
- After a pop at edge N, the next RX entry appears on `fifo_data_o` in cycle N+1, giving one word per clock with RD_N held low.
- Reset asserted mid-transfer:
  - All outputs take their reset values immediately (asynchronous).
  - FIFO contents are discarded.

## Test plan
- Push 0x11111111..0x44444444 (BE=0xF) on `h2f_*`. Hold OE_N=0 and RD_N=0 for 4 cycles. Required: `fifo_data_o` shows the 4 words in order, one per cycle, and `rxf_n_o`=1 in the cycle after the 4th pop.
- With DepthLog2=4, write 16 words (0xA0..0xAF) with `f2h_ready_i`=0. Required:
  - `txe_n_o`=1 after the 16th write.
  - A 17th write raises `overrun_cnt_o` to 1.
  - `f2h_*` later drains 0xA0..0xAF in order.
- RD_N=0 and OE_N=0 on an empty RX FIFO for 300 cycles. Required: `underrun_cnt_o`=255 and no pop.
- Full RX FIFO, with a simultaneous `h2f` push attempt and FPGA pop. Required: `h2f_ready_o` stays 0 in that cycle, and occupancy is 15 afterwards.
- WR_N=0 with OE_N=0 for one cycle. Required: `contention_o`=1, TX occupancy unchanged, and the flag holds until `rst_i`.
- Assert `rst_i` with 3 words in each FIFO. Required: all outputs return to reset values at once, and `txe_n_o`=0 one edge after release.

Source files
------------

// File: rtl/ft601_fifo_responder.sv
// Device-side peer of an FT601 245-synchronous FIFO master: an RX FIFO feeds FPGA reads,
// and FPGA writes land in a TX FIFO that drains to a ready/valid stream.
module ft601_fifo_responder #(
  parameter int unsigned DepthLog2 = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] h2f_data_i,
  input  logic [3:0]  h2f_be_i,
  input  logic        h2f_valid_i,
  output logic        h2f_ready_o,
  output logic [31:0] f2h_data_o,
  output logic [3:0]  f2h_be_o,
  output logic        f2h_valid_o,
  input  logic        f2h_ready_i,
  input  logic [31:0] fifo_data_i,
  output logic [31:0] fifo_data_o,
  output logic        fifo_data_oe_o,
  input  logic [3:0]  fifo_be_i,
  output logic [3:0]  fifo_be_o,
  output logic        rxf_n_o,
  output logic        txe_n_o,
  input  logic        rd_n_i,
  input  logic        wr_n_i,
  input  logic        oe_n_i,
  output logic [7:0]  underrun_cnt_o,
  output logic [7:0]  overrun_cnt_o,
  output logic        contention_o
);

  localparam int unsigned DEPTH = 1 << DepthLog2;
  localparam logic [DepthLog2:0]   CNT_FULL = {1'b1, {DepthLog2{1'b0}}};
  localparam logic [DepthLog2:0]   CNT_ONE  = {{DepthLog2{1'b0}}, 1'b1};
  localparam logic [DepthLog2-1:0] PTR_ONE  = CNT_ONE[DepthLog2-1:0];

  // Each entry is {be, data}.
  logic [35:0] rx_mem [DEPTH];
  logic [35:0] tx_mem [DEPTH];

  logic [DepthLog2-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
  logic [DepthLog2:0]   rx_cnt, rx_cnt_nxt, tx_cnt, tx_cnt_nxt;
  logic [35:0]          rx_head, tx_head;

  logic rx_push, rx_pop, rd_illegal;
  logic tx_push, tx_pop, wr_illegal, bus_clash;

  // Handshake qualifiers use only the registered status flags.
  assign rx_push    = h2f_valid_i & h2f_ready_o;
  assign rx_pop     = ~rd_n_i & ~oe_n_i & ~rxf_n_o;
  assign rd_illegal = ~rd_n_i & ~oe_n_i & rxf_n_o;
  assign bus_clash  = ~wr_n_i & ~oe_n_i;
  assign tx_push    = ~wr_n_i & oe_n_i & ~txe_n_o;
  assign wr_illegal = ~wr_n_i & txe_n_o;
  assign tx_pop     = f2h_valid_o & f2h_ready_i;

  always_comb begin
    rx_cnt_nxt = rx_cnt;
    if (rx_push && !rx_pop)      rx_cnt_nxt = rx_cnt + CNT_ONE;
    else if (!rx_push && rx_pop) rx_cnt_nxt = rx_cnt - CNT_ONE;
  end

  always_comb begin
    tx_cnt_nxt = tx_cnt;
    if (tx_push && !tx_pop)      tx_cnt_nxt = tx_cnt + CNT_ONE;
    else if (!tx_push && tx_pop) tx_cnt_nxt = tx_cnt - CNT_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= {h2f_be_i, h2f_data_i};
    if (tx_push) tx_mem[tx_wr_ptr] <= {fifo_be_i, fifo_data_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_wr_ptr      <= '0;
      rx_rd_ptr      <= '0;
      tx_wr_ptr      <= '0;
      tx_rd_ptr      <= '0;
      rx_cnt         <= '0;
      tx_cnt         <= '0;
      rxf_n_o        <= 1'b1;
      txe_n_o        <= 1'b1;
      h2f_ready_o    <= 1'b0;
      f2h_valid_o    <= 1'b0;
      fifo_data_oe_o <= 1'b0;
      underrun_cnt_o <= '0;
      overrun_cnt_o  <= '0;
      contention_o   <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      rx_cnt         <= rx_cnt_nxt;
      tx_cnt         <= tx_cnt_nxt;
      rxf_n_o        <= (rx_cnt_nxt == '0);
      h2f_ready_o    <= (rx_cnt_nxt != CNT_FULL);
      txe_n_o        <= (tx_cnt_nxt == CNT_FULL);
      f2h_valid_o    <= (tx_cnt_nxt != '0);
      fifo_data_oe_o <= ~oe_n_i;
      if (rd_illegal && (underrun_cnt_o != 8'hFF)) underrun_cnt_o <= underrun_cnt_o + 8'd1;
      if (wr_illegal && (overrun_cnt_o != 8'hFF))  overrun_cnt_o  <= overrun_cnt_o + 8'd1;
      if (bus_clash) contention_o <= 1'b1;
    end
  end

  // Show-ahead heads, forced to zero while empty so stale storage never leaks out.
  assign rx_head     = rx_mem[rx_rd_ptr];
  assign tx_head     = tx_mem[tx_rd_ptr];
  assign fifo_data_o = rxf_n_o ? 32'd0 : rx_head[31:0];
  assign fifo_be_o   = rxf_n_o ? 4'd0 : rx_head[35:32];
  assign f2h_data_o  = f2h_valid_o ? tx_head[31:0] : 32'd0;
  assign f2h_be_o    = f2h_valid_o ? tx_head[35:32] : 4'd0;

endmodule

// File: tb/tb_ft601_fifo_responder.sv
// Bench for ft601_fifo_responder: directed test-plan steps plus random traffic,
// all checked every cycle against a queue-based model of the device.
module tb_ft601_fifo_responder;

  localparam int DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] h2f_data_i;
  logic [3:0]  h2f_be_i;
  logic        h2f_valid_i;
  logic        h2f_ready_o;
  logic [31:0] f2h_data_o;
  logic [3:0]  f2h_be_o;
  logic        f2h_valid_o;
  logic        f2h_ready_i;
  logic [31:0] fifo_data_i;
  logic [31:0] fifo_data_o;
  logic        fifo_data_oe_o;
  logic [3:0]  fifo_be_i;
  logic [3:0]  fifo_be_o;
  logic        rxf_n_o;
  logic        txe_n_o;
  logic        rd_n_i;
  logic        wr_n_i;
  logic        oe_n_i;
  logic [7:0]  underrun_cnt_o;
  logic [7:0]  overrun_cnt_o;
  logic        contention_o;

  ft601_fifo_responder #(.DepthLog2(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .h2f_data_i(h2f_data_i), .h2f_be_i(h2f_be_i), .h2f_valid_i(h2f_valid_i), .h2f_ready_o(h2f_ready_o),
    .f2h_data_o(f2h_data_o), .f2h_be_o(f2h_be_o), .f2h_valid_o(f2h_valid_o), .f2h_ready_i(f2h_ready_i),
    .fifo_data_i(fifo_data_i), .fifo_data_o(fifo_data_o), .fifo_data_oe_o(fifo_data_oe_o),
    .fifo_be_i(fifo_be_i), .fifo_be_o(fifo_be_o), .rxf_n_o(rxf_n_o), .txe_n_o(txe_n_o),
    .rd_n_i(rd_n_i), .wr_n_i(wr_n_i), .oe_n_i(oe_n_i),
    .underrun_cnt_o(underrun_cnt_o), .overrun_cnt_o(overrun_cnt_o), .contention_o(contention_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [35:0] rx_q[$];
  logic [35:0] tx_q[$];
  int          m_urun, m_orun;
  bit          m_cont, m_fresh, m_oe;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rx_q.delete();
    tx_q.delete();
    m_urun  = 0;
    m_orun  = 0;
    m_cont  = 0;
    m_fresh = 1;
    m_oe    = 0;
  endtask

  // Device behaviour over one rising edge, judged from occupancy before the edge.
  task automatic model_edge();
    int rxn, txn;
    bit ready, txe_n;
    rxn   = rx_q.size();
    txn   = tx_q.size();
    ready = !m_fresh && (rxn != DEPTH);
    txe_n = m_fresh || (txn == DEPTH);
    if (!rd_n_i && !oe_n_i) begin
      if (rxn != 0) rx_q.delete(0);
      else if (m_urun < 255) m_urun++;
    end
    if (!wr_n_i && !oe_n_i) m_cont = 1;
    if (!wr_n_i) begin
      if (txe_n) begin
        if (m_orun < 255) m_orun++;
      end else if (oe_n_i) begin
        tx_q.push_back({fifo_be_i, fifo_data_i});
      end
    end
    if ((txn != 0) && f2h_ready_i) tx_q.delete(0);
    if (h2f_valid_i && ready) rx_q.push_back({h2f_be_i, h2f_data_i});
    m_oe    = !oe_n_i;
    m_fresh = 0;
  endtask

  task automatic check_all();
    logic [35:0] rh, th;
    rh = (rx_q.size() != 0) ? rx_q[0] : 36'd0;
    th = (tx_q.size() != 0) ? tx_q[0] : 36'd0;
    chk("rxf_n",      36'(rxf_n_o),        36'(rx_q.size() == 0));
    chk("txe_n",      36'(txe_n_o),        36'(m_fresh || (tx_q.size() == DEPTH)));
    chk("h2f_ready",  36'(h2f_ready_o),    36'(!m_fresh && (rx_q.size() != DEPTH)));
    chk("f2h_valid",  36'(f2h_valid_o),    36'(tx_q.size() != 0));
    chk("fifo_data",  36'(fifo_data_o),    36'(rh[31:0]));
    chk("fifo_be",    36'(fifo_be_o),      36'(rh[35:32]));
    chk("f2h_data",   36'(f2h_data_o),     36'(th[31:0]));
    chk("f2h_be",     36'(f2h_be_o),       36'(th[35:32]));
    chk("oe",         36'(fifo_data_oe_o), 36'(m_oe));
    chk("underrun",   36'(underrun_cnt_o), 36'(m_urun));
    chk("overrun",    36'(overrun_cnt_o),  36'(m_orun));
    chk("contention", 36'(contention_o),   36'(m_cont));
  endtask

  task automatic cyc();
    @(posedge clk_i);
    if (rst_i) model_reset();
    else model_edge();
    @(negedge clk_i);
    check_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int mode;
    rst_i = 1'b1;
    h2f_data_i = '0; h2f_be_i = '0; h2f_valid_i = 1'b0; f2h_ready_i = 1'b0;
    fifo_data_i = '0; fifo_be_i = '0; rd_n_i = 1'b1; wr_n_i = 1'b1; oe_n_i = 1'b1;
    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_all();
    rst_i = 1'b0;
    cyc();
    chk("txe_after_release", 36'(txe_n_o), 36'd0);
    chk("ready_after_release", 36'(h2f_ready_o), 36'd1);

    // Four words in, then read back one per clock.
    h2f_valid_i = 1'b1; h2f_be_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      h2f_data_i = 32'h11111111 * (i + 1);
      cyc();
    end
    h2f_valid_i = 1'b0;
    rd_n_i = 1'b0; oe_n_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("burst_word", 36'(fifo_data_o), 36'(32'h11111111 * (i + 1)));
      cyc();
    end
    chk("rxf_after_burst", 36'(rxf_n_o), 36'd1);
    rd_n_i = 1'b1; oe_n_i = 1'b1;
    cyc();

    // Fill the TX FIFO, overrun once, then drain.
    wr_n_i = 1'b0; f2h_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fifo_data_i = 32'hA0 + 32'(i);
      fifo_be_i   = 4'($urandom);
      cyc();
    end
    chk("txe_when_full", 36'(txe_n_o), 36'd1);
    fifo_data_i = 32'hDEAD;
    cyc();
    chk("overrun_one", 36'(overrun_cnt_o), 36'd1);
    wr_n_i = 1'b1; f2h_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_word", 36'(f2h_data_o), 36'(32'hA0 + 32'(i)));
      cyc();
    end
    chk("drained_empty", 36'(f2h_valid_o), 36'd0);

    // Long illegal read on an empty RX FIFO saturates the counter.
    rd_n_i = 1'b0; oe_n_i = 1'b0;
    repeat (300) cyc();
    chk("underrun_sat", 36'(underrun_cnt_o), 36'd255);
    chk("no_pop_empty", 36'(rxf_n_o), 36'd1);
    rd_n_i = 1'b1; oe_n_i = 1'b1;
    cyc();

    // Full RX FIFO: push attempt and pop in the same cycle.
    h2f_valid_i = 1'b1; h2f_be_i = 4'hF;
    for (int i = 0; i < 16; i++) begin
      h2f_data_i = $urandom;
      cyc();
    end
    h2f_data_i = 32'hBAD0BAD0;
    rd_n_i = 1'b0; oe_n_i = 1'b0;
    chk("ready_low_full", 36'(h2f_ready_o), 36'd0);
    cyc();
    h2f_valid_i = 1'b0;
    n = 0;
    while (!rxf_n_o && n < 40) begin
      cyc();
      n++;
    end
    chk("rx_occ_after_clash", 36'(n), 36'd15);
    rd_n_i = 1'b1; oe_n_i = 1'b1;
    cyc();

    // Write strobe with OE asserted: sticky contention, nothing captured.
    wr_n_i = 1'b0; oe_n_i = 1'b0; fifo_data_i = $urandom;
    cyc();
    wr_n_i = 1'b1; oe_n_i = 1'b1;
    chk("contention_set", 36'(contention_o), 36'd1);
    chk("contention_no_write", 36'(f2h_valid_o), 36'd0);
    repeat (5) cyc();
    chk("contention_sticky", 36'(contention_o), 36'd1);

    // Reset with three words in each FIFO.
    f2h_ready_i = 1'b0; h2f_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      h2f_data_i = $urandom;
      cyc();
    end
    h2f_valid_i = 1'b0; wr_n_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fifo_data_i = $urandom;
      cyc();
    end
    wr_n_i = 1'b1;
    chk("pre_reset_tx", 36'(f2h_valid_o), 36'd1);
    chk("pre_reset_rx", 36'(rxf_n_o), 36'd0);
    #1 rst_i = 1'b1;
    #1;
    model_reset();
    chk("rst_rxf", 36'(rxf_n_o), 36'd1);
    chk("rst_txe", 36'(txe_n_o), 36'd1);
    chk("rst_oe", 36'(fifo_data_oe_o), 36'd0);
    chk("rst_ready", 36'(h2f_ready_o), 36'd0);
    chk("rst_valid", 36'(f2h_valid_o), 36'd0);
    chk("rst_urun", 36'(underrun_cnt_o), 36'd0);
    chk("rst_orun", 36'(overrun_cnt_o), 36'd0);
    chk("rst_cont", 36'(contention_o), 36'd0);
    chk("rst_fifo_data", {fifo_be_o, fifo_data_o}, 36'd0);
    chk("rst_f2h_data", {f2h_be_o, f2h_data_o}, 36'd0);
    repeat (2) cyc();
    rst_i = 1'b0;
    cyc();
    chk("txe_one_edge_after", 36'(txe_n_o), 36'd0);

    // Random traffic with shifting backpressure.
    for (int k = 0; k < 400; k++) begin
      mode = int'($urandom_range(0, 19));
      h2f_valid_i = ($urandom_range(0, 3) >= 32'(k / 100));
      h2f_data_i  = $urandom;
      h2f_be_i    = 4'($urandom);
      f2h_ready_i = ($urandom_range(0, 3) < 32'(k / 100));
      fifo_data_i = $urandom;
      fifo_be_i   = 4'($urandom);
      rd_n_i = 1'b1; wr_n_i = 1'b1; oe_n_i = 1'b1;
      if (mode < 8) begin
        oe_n_i = 1'b0;
        rd_n_i = 1'($urandom_range(0, 1));
      end else if (mode < 18) begin
        wr_n_i = 1'($urandom_range(0, 1));
      end else if (mode == 18) begin
        oe_n_i = 1'b0;
        wr_n_i = 1'b0;
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
